// File: rtl/udp_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : udp_tx_arb
// Brief    : Packet-level round-robin arbiter feeding one tx_pack packetizer
//            from CH_NUM payload sources, with per-packet destination latch.
// Revision : 1.0 - initial release
// ============================================================================
module udp_tx_arb #(
    parameter int CH_NUM = 4,
    parameter int CH_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH_NUM*16-1:0] in_data,
    input  logic [CH_NUM-1:0]    in_vld,
    input  logic [CH_NUM-1:0]    in_sop,
    input  logic [CH_NUM-1:0]    in_eop,
    input  logic [CH_NUM-1:0]    in_mty,
    output logic [CH_NUM-1:0]    in_rdy,
    input  logic [CH_NUM*16-1:0] ch_dport,
    input  logic [CH_NUM*32-1:0] ch_dip,
    output logic [15:0]          tx_data,
    output logic                 tx_vld,
    output logic                 tx_sop,
    output logic                 tx_eop,
    output logic                 tx_mty,
    input  logic                 tx_rdy,
    output logic [15:0]          cfg_dport,
    output logic [31:0]          cfg_dip,
    output logic [CH_W-1:0]      cur_ch,
    output logic                 busy,
    output logic                 err_hdr,
    output logic                 err_sop
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    logic [CH_W-1:0]   r_cur;
    logic [CH_W-1:0]   r_last;
    logic              r_first;
    logic [15:0]       r_dport;
    logic [31:0]       r_dip;
    logic              r_err_hdr;
    logic              r_err_sop;

    logic [CH_NUM-1:0] w_req;
    logic [CH_NUM-1:0] w_hdr;
    logic              w_any_req;
    logic              w_any_hdr;
    logic [CH_W-1:0]   w_win;
    logic [CH_W-1:0]   w_hdr_ch;
    logic [15:0]       w_win_dport;
    logic [31:0]       w_win_dip;
    logic [15:0]       w_g_data;
    logic              w_g_vld;
    logic              w_g_sop;
    logic              w_g_eop;
    logic              w_g_mty;
    logic              w_xfer;
    logic              w_hdr_take;

    // Round-robin winner: smallest circular distance after the last grant.
    always_comb begin
        int d;
        int best;
        d         = 0;
        best      = CH_NUM;
        w_req     = in_vld & in_sop;
        w_hdr     = in_vld & ~in_sop;
        w_any_req = 1'b0;
        w_win     = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (w_req[i]) begin
                d = i - int'(r_last) - 1;
                if (d < 0) begin
                    d = d + CH_NUM;
                end
                if (d < best) begin
                    best      = d;
                    w_win     = CH_W'(i);
                    w_any_req = 1'b1;
                end
            end
        end
    end

    // Lowest-index headless channel, one per cycle.
    always_comb begin
        w_any_hdr = 1'b0;
        w_hdr_ch  = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (w_hdr[i]) begin
                w_any_hdr = 1'b1;
                w_hdr_ch  = CH_W'(i);
            end
        end
    end

    always_comb begin
        w_win_dport = '0;
        w_win_dip   = '0;
        w_g_data    = '0;
        w_g_vld     = 1'b0;
        w_g_sop     = 1'b0;
        w_g_eop     = 1'b0;
        w_g_mty     = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (w_win == CH_W'(i)) begin
                w_win_dport = ch_dport[i*16 +: 16];
                w_win_dip   = ch_dip[i*32 +: 32];
            end
            if (r_cur == CH_W'(i)) begin
                w_g_data = in_data[i*16 +: 16];
                w_g_vld  = in_vld[i];
                w_g_sop  = in_sop[i];
                w_g_eop  = in_eop[i];
                w_g_mty  = in_mty[i];
            end
        end
    end

    // Zero-latency pass-through of the granted channel while busy.
    always_comb begin
        in_rdy     = '0;
        tx_data    = '0;
        tx_vld     = 1'b0;
        tx_sop     = 1'b0;
        tx_eop     = 1'b0;
        tx_mty     = 1'b0;
        w_xfer     = 1'b0;
        w_hdr_take = 1'b0;
        if (r_state == S_BUSY) begin
            tx_data = w_g_data;
            tx_vld  = w_g_vld;
            tx_sop  = w_g_sop;
            tx_eop  = w_g_eop;
            tx_mty  = w_g_mty;
            w_xfer  = w_g_vld && tx_rdy;
            for (int i = 0; i < CH_NUM; i++) begin
                if (r_cur == CH_W'(i)) begin
                    in_rdy[i] = tx_rdy;
                end
            end
        end else if (w_any_hdr && !rst) begin
            w_hdr_take = 1'b1;
            for (int i = 0; i < CH_NUM; i++) begin
                if (w_hdr_ch == CH_W'(i)) begin
                    in_rdy[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cur     <= '0;
            r_last    <= CH_W'(CH_NUM - 1);
            r_first   <= 1'b0;
            r_dport   <= '0;
            r_dip     <= '0;
            r_err_hdr <= 1'b0;
            r_err_sop <= 1'b0;
        end else begin
            r_err_hdr <= 1'b0;
            r_err_sop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_err_hdr <= w_hdr_take;
                    if (w_any_req) begin
                        r_state <= S_BUSY;
                        r_cur   <= w_win;
                        r_last  <= w_win;
                        r_dport <= w_win_dport;
                        r_dip   <= w_win_dip;
                        r_first <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (w_xfer) begin
                        r_first <= 1'b0;
                        if (w_g_sop && !r_first) begin
                            r_err_sop <= 1'b1;
                        end
                        if (w_g_eop) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_dport = r_dport;
    assign cfg_dip   = r_dip;
    assign cur_ch    = r_cur;
    assign busy      = (r_state == S_BUSY);
    assign err_hdr   = r_err_hdr;
    assign err_sop   = r_err_sop;

endmodule
`default_nettype wire
